sdfm_sinc_filt: RTL
===================

// Module: sdfm_sinc_filt
// PURPOSE
//  Parametrised sinc data filter for one sigma-delta modulator channel, successor to the fixed 32-bit filter unit.
//  Integrates the 1-bit stream, decimates by a programmable OSR, applies comb stages, shifts and saturates the result.
//  Holds each result in a one-deep output register with a valid/read handshake and overrun flag.
//  Runs entirely on SYSCLK; modulator bits enter via a one-cycle enable strobe from the input synchroniser.
// PARAMETERS
//  ACC_W  32  integrator/comb width, two's complement, wrap-around arithmetic
//  DEC_W  8   width of decimation count (OSR = cfg_dec+1, 1..2^DEC_W)
//  OUT_W  32  output width; OUT_W <= ACC_W
//  SH_W   5   width of shift control
// PORTS
//  SYSCLK     in   1      system clock
//  SYSRST     in   1      asynchronous reset, active high
//  sd_dsd_in  in   1      modulator data bit, qualified by sd_clk_en
//  sd_clk_en  in   1      one-cycle strobe: sample sd_dsd_in this cycle
//  cfg_en     in   1      filter enable; 0 clears pipeline and FSM
//  cfg_st     in   2      structure: 00 sinc-fast, 01 sinc1, 10 sinc2, 11 sinc3
//  cfg_dec    in   DEC_W  OSR-1
//  cfg_sh     in   SH_W   arithmetic right shift, clamped to ACC_W-8
//  data_rd    in   1      consumer read strobe; clears data_valid
//  data_out   out  OUT_W  filtered, shifted, saturated sample
//  data_valid out  1      sample held in data_out, not yet read
//  data_sat   out  1      data_out was saturated (valid with data_out)
//  data_ovr   out  1      one-cycle pulse: unread sample overwritten
// BEHAVIOUR
//  - Reset or cfg_en=0: integrators, combs, decimation count and FSM cleared; all outputs 0.
//  - Integrator: on sd_clk_en, I1 += (bit ? +1 : -1); I2 += I1; I3 += I2 (old values, all ACC_W wrap).
//  - Decimation: counter increments per sd_clk_en; when count==cfg_dec on a strobe it returns to 0 and raises dec_tick.
//  - Comb: on dec_tick, selected integrator (I1 for sinc1, I2 for sinc2/fast, I3 for sinc3) feeds N comb stages
//    (N = 1/2/3; fast = sinc2 y[n] + y[n-2]).
//  - Shift: arithmetic right by min(cfg_sh, ACC_W-8), then saturate to OUT_W signed range; data_sat set if clipped.
//  - Latency: data_valid rises exactly 2 SYSCLK cycles after the sd_clk_en that produced dec_tick.
//  - FSM: IDLE -> SETTLE on cfg_en=1; SETTLE discards first K results (K=1,2,3,4 for sinc1/2/3/fast);
//    SETTLE -> RUN after K-th dec_tick; RUN publishes every result; cfg_en=0 -> IDLE from any state.
//  - cfg_st or cfg_dec change while enabled: FSM returns to SETTLE, combs cleared; integrators keep running.
//  - Handshake: data_rd with data_valid=1 clears data_valid next cycle. New result while data_valid=1:
//    overwrite data_out, data_valid stays 1, data_ovr pulses. New result and data_rd in same cycle:
//    new result loaded, data_valid stays 1, no data_ovr.
//  - data_rd while data_valid=0: ignored.
//  - sd_clk_en with cfg_en=0: ignored.
// STRUCTURE
//  - Package sdfm_pkg: filter-structure encoding constants (ST_FAST/ST_SINC1/ST_SINC2/ST_SINC3),
//    FSM state enum, settle-count function of structure.
//  - One sub-module sdfm_sinc_comb: N-stage comb with clear, generated from ACC_W.
//  - Integrators, decimator, shifter, FSM and output register stay in the top module.
// TESTING
//  - sinc1, cfg_dec=15, all-ones stream, sh=0 -> after 1 discarded sample, data_out=16 every 16 strobes;
//    all-zeros -> -16.
//  - sinc2/sinc3/fast, cfg_dec=15, all-ones -> 256 / 4096 / 512 after 2/3/4 discarded samples;
//    sinc3 with sh=4 -> 256.
//  - OUT_W=16, sinc3, cfg_dec=63, all-ones -> 262144 clipped to 32767, data_sat=1.
//  - data_rd withheld across two results -> second overwrites, data_ovr one pulse, data_valid stays 1;
//    data_rd in the same cycle as a new result -> no data_ovr.
//  - sh=31 with ACC_W=32 -> behaves as shift of 24.
//  - SYSRST pulse mid-period, then cfg_st change mid-run -> all outputs 0 immediately;
//    settle count restarts, first valid sample correct.

Source files
------------

// File: rtl/sdfm_pkg.sv
// Shared encodings for the sigma-delta sinc filter: structure codes, FSM states,
// and structure-dependent comb depth / settle length.
package sdfm_pkg;

    localparam logic [1:0] ST_FAST  = 2'b00;
    localparam logic [1:0] ST_SINC1 = 2'b01;
    localparam logic [1:0] ST_SINC2 = 2'b10;
    localparam logic [1:0] ST_SINC3 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } fsm_t;

    // Number of results to throw away before the comb history is trustworthy.
    function automatic logic [2:0] settle_cnt(input logic [1:0] st);
        case (st)
            ST_SINC1: return 3'd1;
            ST_SINC2: return 3'd2;
            ST_SINC3: return 3'd3;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] comb_stages(input logic [1:0] st);
        case (st)
            ST_SINC1: return 2'd1;
            ST_SINC3: return 2'd3;
            default:  return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/sdfm_sinc_comb.sv
// Cascaded differentiator chain evaluated on each decimated sample; output taps
// after i_nst stages and is combinational from the current input.
module sdfm_sinc_comb #(
    parameter int ACC_W = 32,
    parameter int N_STG = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_x,
    input  logic [1:0]       i_nst,
    output logic [ACC_W-1:0] o_y
);

    logic [N_STG-1:0][ACC_W-1:0] w_dif;

    for (genvar g = 0; g < N_STG; g++) begin : g_stg
        logic [ACC_W-1:0] w_in;
        logic [ACC_W-1:0] w_out;
        logic [ACC_W-1:0] r_z;

        if (g == 0) begin : g_first
            assign w_in = i_x;
        end else begin : g_next
            assign w_in = g_stg[g-1].w_out;
        end

        assign w_out    = w_in - r_z;
        assign w_dif[g] = w_out;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_z <= '0;
            else if (i_clr)
                r_z <= '0;
            else if (i_en)
                r_z <= w_in;
        end
    end

    always_comb begin
        o_y = w_dif[0];
        for (int k = 1; k < N_STG; k++)
            if (int'(i_nst) == k + 1)
                o_y = w_dif[k];
    end

endmodule

// File: rtl/sdfm_sinc_filt.sv
// Sinc data filter for one sigma-delta channel: integrate, decimate, comb,
// shift/saturate, then hold the sample in a one-deep register with overrun flag.
module sdfm_sinc_filt
    import sdfm_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int DEC_W = 8,
    parameter int OUT_W = 32,
    parameter int SH_W  = 5
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    input  logic             sd_dsd_in,
    input  logic             sd_clk_en,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_st,
    input  logic [DEC_W-1:0] cfg_dec,
    input  logic [SH_W-1:0]  cfg_sh,
    input  logic             data_rd,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    output logic             data_sat,
    output logic             data_ovr
);

    localparam int SH_MAX = ACC_W - 8;

    logic [ACC_W-1:0]        r_i1, r_i2, r_i3;
    logic [DEC_W-1:0]        r_cnt, r_dec_q;
    logic [1:0]              r_st_q;
    logic                    r_en_q, r_tick;
    logic [ACC_W-1:0]        r_yd1, r_yd2;
    fsm_t                    r_state, w_state_nx;
    logic [2:0]              r_settle;
    logic [OUT_W-1:0]        r_out;
    logic                    r_valid, r_sat, r_ovr;

    logic                    w_strb, w_chg, w_clr, w_tick, w_pub, w_last, w_ovf;
    logic [ACC_W-1:0]        w_csel, w_y, w_yf;
    logic [1:0]              w_nst;
    logic [SH_W-1:0]         w_shamt;
    logic signed [ACC_W-1:0] w_sh;
    logic [ACC_W-OUT_W:0]    w_hi;
    logic [OUT_W-1:0]        w_res;

    // A config edit only counts once the filter was already enabled; the
    // enable edge itself is handled by IDLE -> SETTLE.
    assign w_strb = cfg_en & sd_clk_en;
    assign w_chg  = cfg_en & r_en_q & ((cfg_st != r_st_q) | (cfg_dec != r_dec_q));
    assign w_clr  = ~cfg_en | w_chg;
    assign w_tick = w_strb & (r_cnt == cfg_dec) & ~w_chg;

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_st_q  <= '0;
            r_dec_q <= '0;
            r_en_q  <= 1'b0;
        end else begin
            r_st_q  <= cfg_st;
            r_dec_q <= cfg_dec;
            r_en_q  <= cfg_en;
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else if (!cfg_en) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else if (w_strb) begin
            r_i1 <= sd_dsd_in ? r_i1 + ACC_W'(1) : r_i1 - ACC_W'(1);
            r_i2 <= r_i2 + r_i1;
            r_i3 <= r_i3 + r_i2;
        end
    end

    // The decimation phase restarts on a config edit so a smaller OSR never
    // leaves the count stranded above cfg_dec.
    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_strb)
                r_cnt <= (r_cnt == cfg_dec) ? '0 : r_cnt + DEC_W'(1);
        end
    end

    always_comb begin
        case (cfg_st)
            ST_SINC1: w_csel = r_i1;
            ST_SINC3: w_csel = r_i3;
            default:  w_csel = r_i2;
        endcase
    end

    assign w_nst = comb_stages(cfg_st);

    sdfm_sinc_comb #(.ACC_W(ACC_W), .N_STG(3)) u_comb (
        .clk   (SYSCLK),
        .rst   (SYSRST),
        .i_clr (w_clr),
        .i_en  (r_tick),
        .i_x   (w_csel),
        .i_nst (w_nst),
        .o_y   (w_y)
    );

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_yd1 <= '0;
            r_yd2 <= '0;
        end else if (w_clr) begin
            r_yd1 <= '0;
            r_yd2 <= '0;
        end else if (r_tick) begin
            r_yd1 <= w_y;
            r_yd2 <= r_yd1;
        end
    end

    assign w_yf    = (cfg_st == ST_FAST) ? w_y + r_yd2 : w_y;
    assign w_shamt = (int'(cfg_sh) > SH_MAX) ? SH_W'(SH_MAX) : cfg_sh;
    assign w_sh    = $signed(w_yf) >>> w_shamt;
    // Fits OUT_W only if every bit from the OUT_W sign position up matches.
    assign w_hi    = w_sh[ACC_W-1:OUT_W-1];
    assign w_ovf   = ~(&w_hi) & (|w_hi);
    assign w_res   = !w_ovf     ? w_sh[OUT_W-1:0] :
                     w_sh[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                     {1'b0, {(OUT_W-1){1'b1}}};

    assign w_last = (r_settle == settle_cnt(cfg_st) - 3'd1);

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_clr || r_state != S_SETTLE)
                r_settle <= '0;
            else if (r_tick)
                r_settle <= r_settle + 3'd1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (!cfg_en)
            w_state_nx = S_IDLE;
        else if (w_chg)
            w_state_nx = S_SETTLE;
        else begin
            case (r_state)
                S_IDLE:   w_state_nx = S_SETTLE;
                S_SETTLE: if (r_tick && w_last) w_state_nx = S_RUN;
                default:  w_state_nx = r_state;
            endcase
        end
    end

    always_comb begin
        w_pub = 1'b0;
        if (r_state == S_RUN && r_tick && !w_clr)
            w_pub = 1'b1;
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (!cfg_en) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_pub & r_valid & ~data_rd;
            if (w_pub) begin
                r_out   <= w_res;
                r_sat   <= w_ovf;
                r_valid <= 1'b1;
            end else if (data_rd) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_out;
    assign data_valid = r_valid;
    assign data_sat   = r_sat;
    assign data_ovr   = r_ovr;

endmodule
